// File: rtl/pc_source_reg_if.sv
// Bundle of the PC source selector's request and status signals.
// Latency: none; wires only. Backpressure: none; requests are accepted or rejected each cycle.
// Ports: master = the requester (drives sources, select, write strobes and err_clr);
//        slave  = pc_source_reg (drives pc_out, pc_prev, next_pc, pc_updated and the error flags).
interface pc_source_reg_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = 3
);
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          src_sel;
  logic                      pc_write;
  logic                      pc_write_cond;
  logic                      cond_true;
  logic                      err_clr;
  logic [DATA_W-1:0]         pc_out;
  logic [DATA_W-1:0]         pc_prev;
  logic [DATA_W-1:0]         next_pc;
  logic                      pc_updated;
  logic                      sel_err;
  logic                      align_err;

  modport master (
    output src_data, src_sel, pc_write, pc_write_cond, cond_true, err_clr,
    input  pc_out, pc_prev, next_pc, pc_updated, sel_err, align_err
  );

  modport slave (
    input  src_data, src_sel, pc_write, pc_write_cond, cond_true, err_clr,
    output pc_out, pc_prev, next_pc, pc_updated, sel_err, align_err
  );
endinterface

// File: rtl/pc_source_reg.sv
// PC source selector with program-counter register, previous-PC copy and sticky error flags.
// Latency: next_pc is combinational; a committed write shows on pc_out/pc_prev one cycle later.
// Backpressure: none; every request either commits or raises an error flag in the same cycle.
// Ports: clk (rising edge), rst (async, active-high), bus (pc_source_reg_if.slave):
//   src_data/src_sel select the target, pc_write/pc_write_cond/cond_true request the write,
//   err_clr clears sel_err/align_err; pc_out, pc_prev, pc_updated and the flags are registered.
module pc_source_reg #(
  parameter int              DATA_W      = 32,
  parameter int              NUM_SRC     = 5,
  parameter int              SEL_W       = 3,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter bit              ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  pc_source_reg_if.slave  bus
);

  logic [DATA_W-1:0] next_pc;
  logic              req;
  logic              sel_ok;
  logic              al_ok;
  logic              commit;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              upd_q, upd_d;
  logic              sel_err_q, sel_err_d;
  logic              align_err_q, align_err_d;

  // Explicit compare-per-source mux so an out-of-range select yields 0
  // rather than an out-of-bounds part-select.
  always_comb begin
    next_pc = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.src_sel == SEL_W'(k)) begin
        next_pc = bus.src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // A false branch condition is simply "no request", never an error.
  assign req    = bus.pc_write | (bus.pc_write_cond & bus.cond_true);
  // One extra bit so NUM_SRC == 2**SEL_W is representable.
  assign sel_ok = ({1'b0, bus.src_sel} < (SEL_W+1)'(NUM_SRC));
  assign al_ok  = (ALIGN_CHECK == 1'b0) || (next_pc[1:0] == 2'b00);
  assign commit = req & sel_ok & al_ok;

  always_comb begin
    pc_d        = pc_q;
    prev_d      = prev_q;
    upd_d       = commit;
    sel_err_d   = sel_err_q;
    align_err_d = align_err_q;

    if (commit) begin
      pc_d   = next_pc;
      prev_d = pc_q;
    end

    // Clear first, then set: a fault in the clearing cycle keeps the flag up.
    if (bus.err_clr) begin
      sel_err_d   = 1'b0;
      align_err_d = 1'b0;
    end
    if (req && !sel_ok) begin
      sel_err_d = 1'b1;
    end
    // Alignment only matters once the select itself is legal.
    if (req && sel_ok && !al_ok) begin
      align_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      prev_q      <= RESET_PC;
      upd_q       <= 1'b0;
      sel_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      prev_q      <= prev_d;
      upd_q       <= upd_d;
      sel_err_q   <= sel_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.next_pc    = next_pc;
  assign bus.pc_out     = pc_q;
  assign bus.pc_prev    = prev_q;
  assign bus.pc_updated = upd_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.align_err  = align_err_q;

endmodule

// File: tb/tb_pc_source_reg.sv
// Checks three pc_source_reg instances side by side against a behavioural model:
// u0 default (32b, 5 sources, alignment checked), u1 alignment check off with RESET_PC 0x1000,
// u2 16b / 3 sources / 2-bit select. All three share the stimulus variables below.
module tb_pc_source_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_source_reg_if #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3)) if0 ();
  pc_source_reg_if #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3)) if1 ();
  pc_source_reg_if #(.DATA_W(16), .NUM_SRC(3), .SEL_W(2)) if2 ();

  pc_source_reg #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3), .RESET_PC(32'h0000_0000), .ALIGN_CHECK(1'b1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  pc_source_reg #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3), .RESET_PC(32'h0000_1000), .ALIGN_CHECK(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  pc_source_reg #(.DATA_W(16), .NUM_SRC(3), .SEL_W(2), .RESET_PC(16'h0000), .ALIGN_CHECK(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  // Shared stimulus.
  logic [31:0] srcs [5];
  logic [2:0]  sel;
  logic        wr, wc, ct, clr;

  // Model state per instance.
  logic [31:0] m_pc   [3];
  logic [31:0] m_prev [3];
  logic        m_upd  [3];
  logic        m_se   [3];
  logic        m_ae   [3];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int nsrc(int d);
    return (d == 2) ? 3 : 5;
  endfunction

  function automatic logic [31:0] dmask(int d);
    return (d == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit achk(int d);
    return (d != 1);
  endfunction

  function automatic logic [31:0] rstpc(int d);
    return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  // Select index as seen by instance d (u2 only has two select bits).
  function automatic int sel_of(int d);
    return (d == 2) ? int'(sel[1:0]) : int'(sel);
  endfunction

  function automatic logic [31:0] tgt(int d);
    if (sel_of(d) >= nsrc(d)) return 32'h0;
    return srcs[sel_of(d)] & dmask(d);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_pc[d] = rstpc(d); m_prev[d] = rstpc(d);
      m_upd[d] = 1'b0; m_se[d] = 1'b0; m_ae[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit req, sok, aok;
      logic [31:0] t;
      req = wr || (wc && ct);
      sok = sel_of(d) < nsrc(d);
      t   = tgt(d);
      aok = !achk(d) || (t % 4 == 0);
      m_upd[d] = req && sok && aok;
      if (req && sok && aok) begin
        m_prev[d] = m_pc[d];
        m_pc[d]   = t;
      end
      if (clr) begin m_se[d] = 1'b0; m_ae[d] = 1'b0; end
      if (req && !sok) m_se[d] = 1'b1;
      if (req && sok && !aok) m_ae[d] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if0.src_data = {srcs[4], srcs[3], srcs[2], srcs[1], srcs[0]};
    if1.src_data = {srcs[4], srcs[3], srcs[2], srcs[1], srcs[0]};
    if2.src_data = {srcs[2][15:0], srcs[1][15:0], srcs[0][15:0]};
    if0.src_sel = sel;       if1.src_sel = sel;       if2.src_sel = sel[1:0];
    if0.pc_write = wr;       if1.pc_write = wr;       if2.pc_write = wr;
    if0.pc_write_cond = wc;  if1.pc_write_cond = wc;  if2.pc_write_cond = wc;
    if0.cond_true = ct;      if1.cond_true = ct;      if2.cond_true = ct;
    if0.err_clr = clr;       if1.err_clr = clr;       if2.err_clr = clr;
  endtask

  task automatic check_next(input string tag);
    chk({tag, "/u0 next_pc"}, if0.next_pc, tgt(0));
    chk({tag, "/u1 next_pc"}, if1.next_pc, tgt(1));
    chk({tag, "/u2 next_pc"}, {16'h0, if2.next_pc}, tgt(2));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "/u0 pc_out"},  if0.pc_out,  m_pc[0]);
    chk({tag, "/u0 pc_prev"}, if0.pc_prev, m_prev[0]);
    chk({tag, "/u0 flags"}, {29'h0, if0.pc_updated, if0.sel_err, if0.align_err},
        {29'h0, m_upd[0], m_se[0], m_ae[0]});
    chk({tag, "/u1 pc_out"},  if1.pc_out,  m_pc[1]);
    chk({tag, "/u1 pc_prev"}, if1.pc_prev, m_prev[1]);
    chk({tag, "/u1 flags"}, {29'h0, if1.pc_updated, if1.sel_err, if1.align_err},
        {29'h0, m_upd[1], m_se[1], m_ae[1]});
    chk({tag, "/u2 pc_out"},  {16'h0, if2.pc_out},  m_pc[2]);
    chk({tag, "/u2 pc_prev"}, {16'h0, if2.pc_prev}, m_prev[2]);
    chk({tag, "/u2 flags"}, {29'h0, if2.pc_updated, if2.sel_err, if2.align_err},
        {29'h0, m_upd[2], m_se[2], m_ae[2]});
  endtask

  // Entered shortly after a rising edge; returns 1 time unit after the next one.
  task automatic step(input string tag);
    drive();
    #1;
    check_next(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  // Reset raised between edges: registers must return before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) srcs[k] = 32'h100 * (k + 1);
    sel = '0; wr = 0; wc = 0; ct = 0; clr = 0;
    drive();
    model_reset();

    // Reset held across edges.
    repeat (3) @(posedge clk);
    #2;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Select sweep: pc_prev trails, pc_updated stays high; u2 faults on sel 3.
    wr = 1;
    for (int s = 0; s < 5; s++) begin
      sel = 3'(s);
      step("sweep");
    end
    wr = 0; clr = 1; step("clear");
    clr = 0;

    // Branch not taken, then taken.
    wc = 1; sel = 3'd1; ct = 0; step("br_nt");
    ct = 1; step("br_t");
    wc = 0; ct = 0;

    // Bad select, sticky, set beats clear, then cleared.
    wr = 1; sel = 3'd6; step("badsel");
    wr = 0; step("badsel_hold");
    wr = 1; clr = 1; step("clr_vs_set");
    wr = 0; step("clr_done");
    clr = 0;

    // Misaligned target: flagged where checked, committed on u1.
    srcs[0] = 32'h0000_0102; wr = 1; sel = 3'd0; step("misalign");
    wr = 0; step("misalign_hold");
    clr = 1; step("misalign_clr");
    clr = 0;

    // Both strobes with false condition: pc_write still commits.
    wr = 1; wc = 1; ct = 0; sel = 3'd2; step("both");
    wc = 0;

    // Async reset mid-cycle after PC = 0x40, then first commit after release.
    srcs[0] = 32'h0000_0040; sel = 3'd0; step("pc40");
    wr = 0; step("idle");
    async_reset("async_rst");
    wr = 1; sel = 3'd1; step("post_rst");
    wr = 0; step("post_rst_idle");

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 5; k++) begin
        srcs[k] = $urandom;
        if ($urandom_range(0, 3) != 0) srcs[k][1:0] = 2'b00;
      end
      sel = 3'($urandom_range(0, 7));
      wr  = ($urandom_range(0, 2) == 0);
      wc  = 1'($urandom_range(0, 1));
      ct  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
